// File: rtl/adc_sample_frontend.sv
// Codec ADC front end: edge-captures L/R frames, mixes to mono,
// boxcar-decimates by 2**LOG2_DECIM and watches for a stalled codec.
module adc_sample_frontend #(
    parameter int K          = 24,
    parameter int LOG2_DECIM = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ready,
    input  logic [K-1:0] L_in,
    input  logic [K-1:0] R_in,
    input  logic         src_sel,
    output logic [K-1:0] data_out,
    output logic         sample,
    output logic         stalled
);

    localparam int AW = K + LOG2_DECIM;
    localparam int CW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_DECIM) - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic                 ready_q;
    logic [K-1:0]         capl_q;
    logic [K-1:0]         capr_q;
    logic                 cap_v_q;
    logic signed [K-1:0]  mix_q;
    logic signed [K-1:0]  mix_d;
    logic                 mix_v_q;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] sum;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [CW-1:0]        cnt_base;
    logic [K-1:0]         dout_q;
    logic [K-1:0]         dout_d;
    logic                 sample_q;
    logic                 sample_d;
    logic [IW-1:0]        idle_q;
    logic [IW-1:0]        idle_d;
    logic                 stall_q;
    logic                 stall_d;
    logic                 cap;
    logic                 tmo;
    logic signed [K:0]    lr_sum;

    always_comb begin
        cap    = ready & ~ready_q;
        lr_sum = $signed({capl_q[K-1], capl_q})
               + $signed({capr_q[K-1], capr_q});
        mix_d  = src_sel ? K'(lr_sum >>> 1) : $signed(capl_q);
    end

    // Timeout fires only on the edge the idle count reaches TIMEOUT;
    // a capture on that same edge takes priority.
    always_comb begin
        tmo     = ~cap & (idle_q == IDLE_MAX - 1'b1);
        idle_d  = idle_q;
        stall_d = stall_q;
        if (cap) begin
            idle_d  = '0;
            stall_d = 1'b0;
        end else begin
            if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
            if (tmo) stall_d = 1'b1;
        end
    end

    always_comb begin
        acc_base = tmo ? '0 : acc_q;
        cnt_base = tmo ? '0 : cnt_q;
        sum      = acc_base + AW'(mix_q);
        acc_d    = acc_base;
        cnt_d    = cnt_base;
        dout_d   = dout_q;
        sample_d = 1'b0;
        if (mix_v_q) begin
            if (cnt_base == CNT_LAST) begin
                dout_d   = K'(sum >>> LOG2_DECIM);
                sample_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= 1'b1;
            capl_q   <= '0;
            capr_q   <= '0;
            cap_v_q  <= 1'b0;
            mix_q    <= '0;
            mix_v_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            sample_q <= 1'b0;
            idle_q   <= '0;
            stall_q  <= 1'b0;
        end else begin
            ready_q <= ready;
            if (cap) begin
                capl_q <= L_in;
                capr_q <= R_in;
            end
            cap_v_q <= cap;
            if (cap_v_q) mix_q <= mix_d;
            mix_v_q  <= cap_v_q;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            sample_q <= sample_d;
            idle_q   <= idle_d;
            stall_q  <= stall_d;
        end
    end

    assign data_out = dout_q;
    assign sample   = sample_q;
    assign stalled  = stall_q;

endmodule

// File: tb/tb_adc_sample_frontend.sv
// Bench for adc_sample_frontend: three instances (pass-through,
// decimate-by-4, short watchdog) share one stimulus stream.
module tb_adc_sample_frontend;

    logic        clk;
    logic        reset;
    logic        ready;
    logic [23:0] l_in;
    logic [23:0] r_in;
    logic        sel;
    logic [23:0] d0, d2, dw;
    logic        s0, s2, sw;
    logic        st0, st2, stw;

    adc_sample_frontend #(.K(24), .LOG2_DECIM(0), .TIMEOUT(4096)) u_d0 (
        .clk(clk), .reset(reset), .ready(ready), .L_in(l_in), .R_in(r_in),
        .src_sel(sel), .data_out(d0), .sample(s0), .stalled(st0)
    );
    adc_sample_frontend #(.K(24), .LOG2_DECIM(2), .TIMEOUT(256)) u_d2 (
        .clk(clk), .reset(reset), .ready(ready), .L_in(l_in), .R_in(r_in),
        .src_sel(sel), .data_out(d2), .sample(s2), .stalled(st2)
    );
    adc_sample_frontend #(.K(24), .LOG2_DECIM(2), .TIMEOUT(16)) u_wd (
        .clk(clk), .reset(reset), .ready(ready), .L_in(l_in), .R_in(r_in),
        .src_sel(sel), .data_out(dw), .sample(sw), .stalled(stw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cnt0 = 0;
    int cnt2 = 0;
    int cntw = 0;
    longint q0[$];
    longint q2[$];
    longint blk[$];

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        s;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl[8];

    function automatic longint sx(logic [23:0] v);
        return longint'($signed(v));
    endfunction

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: mono value is floor of the mean, block output is floor
    // of the mean of four consecutive mono values.
    function automatic void model_frame(logic [23:0] l, logic [23:0] r,
                                        logic s);
        longint m;
        longint acc;
        m = s ? ((sx(l) + sx(r)) >>> 1) : sx(l);
        q0.push_back(m);
        blk.push_back(m);
        if (blk.size() == 4) begin
            acc = 0;
            foreach (blk[i]) acc += blk[i];
            q2.push_back(acc >>> 2);
            blk.delete();
        end
    endfunction

    always @(negedge clk) begin
        if (s0) begin
            cnt0++;
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d0_unexpected_strobe: got data %0d", sx(d0));
            end else begin
                check("d0_stream", sx(d0), q0.pop_front());
            end
        end
        if (s2) begin
            cnt2++;
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d2_unexpected_strobe: got data %0d", sx(d2));
            end else begin
                check("d2_stream", sx(d2), q2.pop_front());
            end
        end
        if (sw) cntw++;
    end

    task automatic do_reset(logic rdy);
        check("d0_pending", q0.size(), 0);
        check("d2_pending", q2.size(), 0);
        q0.delete();
        q2.delete();
        @(negedge clk);
        reset = 1'b1;
        ready = rdy;
        @(negedge clk);
        check("rst_d0", sx(d0), 0);
        check("rst_d2", sx(d2), 0);
        check("rst_dw", sx(dw), 0);
        check("rst_s2", s2, 0);
        check("rst_st2", st2, 0);
        check("rst_stw", stw, 0);
        reset = 1'b0;
        blk.delete();
    endtask

    task automatic frame(logic [23:0] l, logic [23:0] r, logic s,
                         int hold, int gap);
        @(negedge clk);
        l_in  = l;
        r_in  = r;
        sel   = s;
        ready = 1'b1;
        model_frame(l, r, s);
        repeat (hold) @(negedge clk);
        ready = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c2, cw;
        reset = 1'b1;
        ready = 1'b0;
        l_in  = '0;
        r_in  = '0;
        sel   = 1'b0;

        tbl[0] = '{24'h000100, 24'h000000, 1'b0, 24'h000100};
        tbl[1] = '{24'h7FFFFF, 24'h7FFFFF, 1'b1, 24'h7FFFFF};
        tbl[2] = '{24'h800000, 24'h800001, 1'b1, 24'h800000};
        tbl[3] = '{24'h000003, 24'hFFFFFC, 1'b1, 24'hFFFFFF};
        tbl[4] = '{24'h123456, 24'hABCDEF, 1'b0, 24'h123456};
        tbl[5] = '{24'h000005, 24'h000006, 1'b1, 24'h000005};
        tbl[6] = '{24'hFFFFFB, 24'h000000, 1'b1, 24'hFFFFFD};
        tbl[7] = '{24'h800000, 24'h7FFFFF, 1'b1, 24'hFFFFFF};

        // ready held high across reset release gives no capture
        do_reset(1'b1);
        c0 = cnt0;
        repeat (10) @(negedge clk);
        check("t1_no_capture", cnt0 - c0, 0);
        ready = 1'b0;
        @(negedge clk);
        l_in  = 24'h000100;
        r_in  = '0;
        sel   = 1'b0;
        ready = 1'b1;
        model_frame(l_in, r_in, sel);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t1_early", s0, 0);
        @(posedge clk);
        #1;
        check("t1_strobe", s0, 1);
        check("t1_data", sx(d0), 256);
        @(negedge clk);
        ready = 1'b0;
        drain();

        do_reset(1'b0);
        foreach (tbl[i]) begin
            c0 = cnt0;
            frame(tbl[i].l, tbl[i].r, tbl[i].s, 1, 1);
            for (int k = 0; k < 10 && cnt0 == c0; k++) @(negedge clk);
            check("tbl_strobe", cnt0 - c0, 1);
            check("tbl_data", sx(d0), sx(tbl[i].exp));
        end
        drain();

        do_reset(1'b0);
        c2 = cnt2;
        for (int i = 1; i <= 4; i++) frame(24'(4 * i), '0, 1'b0, 1, 1);
        drain();
        check("t2_one_strobe", cnt2 - c2, 1);
        check("t2_avg10", sx(d2), 10);
        frame(24'hFFFFFF, '0, 1'b0, 1, 1);
        frame(24'hFFFFFF, '0, 1'b0, 1, 1);
        frame(24'hFFFFFF, '0, 1'b0, 1, 1);
        frame(24'hFFFFFE, '0, 1'b0, 1, 1);
        drain();
        check("t2_floor", sx(d2), -2);

        // long ready levels, then ready toggling every cycle
        c0 = cnt0;
        c2 = cnt2;
        for (int i = 0; i < 8; i++) frame(24'(3 * i + 1), '0, 1'b0, 50, 2);
        drain();
        check("t4_level_d2", cnt2 - c2, 2);
        check("t4_level_d0", cnt0 - c0, 8);
        c0 = cnt0;
        c2 = cnt2;
        for (int i = 0; i < 8; i++) begin
            frame(24'($urandom), 24'($urandom), 1'($urandom), 1, 1);
        end
        drain();
        check("t4_toggle_d2", cnt2 - c2, 2);
        check("t4_toggle_d0", cnt0 - c0, 8);

        // watchdog discards the partial block
        do_reset(1'b0);
        cw = cntw;
        frame(24'd100, '0, 1'b0, 1, 1);
        @(negedge clk);
        l_in  = 24'd100;
        ready = 1'b1;
        model_frame(l_in, r_in, sel);
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("t5_not_yet", stw, 0);
        @(posedge clk);
        #1;
        check("t5_stalled", stw, 1);
        check("t5_no_strobe", cntw - cw, 0);
        @(negedge clk);
        l_in  = 24'd20;
        ready = 1'b1;
        model_frame(l_in, r_in, sel);
        @(posedge clk);
        #1;
        check("t5_clear", stw, 0);
        @(negedge clk);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) frame(24'd20, '0, 1'b0, 1, 1);
        drain();
        check("t5_one_strobe", cntw - cw, 1);
        check("t5_data", sx(dw), 20);

        // reset mid-block
        do_reset(1'b0);
        c2 = cnt2;
        for (int i = 0; i < 3; i++) frame(24'd9, '0, 1'b0, 1, 1);
        repeat (4) @(negedge clk);
        do_reset(1'b0);
        check("t6_no_strobe", cnt2 - c2, 0);
        for (int i = 0; i < 4; i++) frame(24'd7, '0, 1'b0, 1, 1);
        drain();
        check("t6_one_strobe", cnt2 - c2, 1);
        check("t6_data", sx(d2), 7);

        do_reset(1'b0);
        for (int i = 0; i < 300; i++) begin
            frame(24'($urandom), 24'($urandom), 1'($urandom),
                  int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        end
        drain();
        check("rand_q0_empty", q0.size(), 0);
        check("rand_q2_empty", q2.size(), 0);
        check("rand_no_stall", st2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
